mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_port_arb_pkg.sv | 20 ++
 rtl/mem_port_arb.sv | 155 +++++++++++++++
 tb/tb_mem_port_arb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter: FSM state
// encodings, owner codes and width constants.
package mem_port_arb_pkg;

   localparam int ARB_ADDR_W_DEF = 32;
   localparam int ARB_DATA_W_DEF = 32;
   localparam int ARB_WEN_W      = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_OWN_INST = 1'b0,
      ARB_OWN_DATA = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mem_port_arb.sv
// Two-master (fetch / load-store) arbiter onto one non-pipelined memory port.
// Optional macro ARB_ROUND_ROBIN_EN replaces fixed data priority with round robin.
module mem_port_arb
   import mem_port_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W_DEF,
   parameter int DATA_W = ARB_DATA_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inst_req,
   input  logic [ADDR_W-1:0]    inst_addr,
   output logic [DATA_W-1:0]    inst_rdata,
   output logic                 inst_rvalid,
   input  logic                 data_req,
   input  logic [ARB_WEN_W-1:0] data_wen,
   input  logic [ADDR_W-1:0]    data_addr,
   input  logic [DATA_W-1:0]    data_wdata,
   output logic [DATA_W-1:0]    data_rdata,
   output logic                 data_rvalid,
   output logic                 mem_req,
   output logic [ARB_WEN_W-1:0] mem_wen,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic                 mem_addr_ok,
   input  logic                 mem_data_ok,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 stallreq
);

   arb_state_e             state_q, state_d;
   arb_owner_e             owner_q, owner_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [ARB_WEN_W-1:0]   wen_q, wen_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   arb_owner_e             grant_s;
   logic                   done_s;

`ifdef ARB_ROUND_ROBIN_EN
   // Pointer holds the most recently granted owner; a tie goes to the other one.
   arb_owner_e             rr_q, rr_d;

   function automatic arb_owner_e pick_owner(input logic i_req, input logic d_req,
                                             input arb_owner_e last);
      if (i_req && d_req) begin
         return (last == ARB_OWN_DATA) ? ARB_OWN_INST : ARB_OWN_DATA;
      end else if (d_req) begin
         return ARB_OWN_DATA;
      end else begin
         return ARB_OWN_INST;
      end
   endfunction

   assign grant_s = pick_owner(inst_req, data_req, rr_q);
`else
   function automatic arb_owner_e pick_owner(input logic i_req, input logic d_req);
      if (d_req) begin
         return ARB_OWN_DATA;
      end else if (i_req) begin
         return ARB_OWN_INST;
      end else begin
         return ARB_OWN_INST;
      end
   endfunction

   assign grant_s = pick_owner(inst_req, data_req);
`endif

   // Next-state and registered-field selection.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      rr_d    = rr_q;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (inst_req || data_req) begin
               owner_d = grant_s;
               state_d = ARB_REQ;
`ifdef ARB_ROUND_ROBIN_EN
               rr_d    = grant_s;
`endif
               if (grant_s == ARB_OWN_DATA) begin
                  addr_d  = data_addr;
                  wen_d   = data_wen;
                  wdata_d = data_wdata;
               end else begin
                  addr_d  = inst_addr;
                  wen_d   = {ARB_WEN_W{1'b0}};
                  wdata_d = {DATA_W{1'b0}};
               end
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_REQ: begin
            if (mem_addr_ok) begin
               state_d = ARB_RESP;
            end else begin
               state_d = ARB_REQ;
            end
         end
         ARB_RESP: begin
            if (mem_data_ok) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = ARB_RESP;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State and transaction field registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= ARB_OWN_INST;
         addr_q  <= {ADDR_W{1'b0}};
         wen_q   <= {ARB_WEN_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
         rr_q    <= ARB_OWN_INST;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         rr_q    <= rr_d;
`endif
      end
   end

   // Reset gates the strobes so nothing is requested or completed while rst is high.
   assign done_s      = (state_q == ARB_RESP) && mem_data_ok && !rst;
   assign mem_req     = (state_q == ARB_REQ) && !rst;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_wen     = (owner_q == ARB_OWN_DATA) ? wen_q : {ARB_WEN_W{1'b0}};
   assign inst_rvalid = done_s && (owner_q == ARB_OWN_INST);
   assign data_rvalid = done_s && (owner_q == ARB_OWN_DATA);
   assign inst_rdata  = mem_rdata;
   assign data_rdata  = mem_rdata;
   assign stallreq    = (inst_req && !inst_rvalid) || (data_req && !data_rvalid);

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_rvalid;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_rvalid;
   logic        mem_req;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;
   logic        stallreq;

   int n_cmp = 0;
   int n_err = 0;

   mem_port_arb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_rvalid(data_rvalid),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .stallreq(stallreq)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst_req = 1'b0; inst_addr = 32'h0;
      data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
      n_cmp++; if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%0h%0h exp=00", inst_rvalid, data_rvalid); end
      n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0h exp=0", stallreq); end
      // Drive into REQ, then assert reset: mem_req must drop while rst is high.
      step(); inst_req = 1'b1; inst_addr = 32'h0000_0040;
      step(); #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL reset_pre_req got=%0h exp=1", mem_req); end
      step(); rst = 1'b1; inst_req = 1'b0; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_during_req got=%0h exp=0", mem_req); end
      step(); rst = 1'b0; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_after_req got=%0h exp=0", mem_req); end
   endtask

   task automatic test_lone_fetch();
      apply_reset();
      step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #1;
      n_cmp++; if (mem_req !== 1'b0 || stallreq !== 1'b1) begin n_err++; $display("FAIL fetch_c0 got req=%0h stall=%0h exp req=0 stall=1", mem_req, stallreq); end
      step(); #1;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0000 || mem_wen !== 4'h0) begin n_err++; $display("FAIL fetch_c1 got req=%0h addr=%h wen=%h exp 1 bfc00000 0", mem_req, mem_addr, mem_wen); end
      n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL fetch_c1_stall got=%0h exp=1", stallreq); end
      step(); mem_addr_ok = 1'b1; #1;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0000 || stallreq !== 1'b1) begin n_err++; $display("FAIL fetch_c2 got req=%0h addr=%h stall=%0h", mem_req, mem_addr, stallreq); end
      step(); mem_addr_ok = 1'b0; #1;
      n_cmp++; if (mem_req !== 1'b0 || inst_rvalid !== 1'b0 || stallreq !== 1'b1) begin n_err++; $display("FAIL fetch_c3 got req=%0h rv=%0h stall=%0h exp 0 0 1", mem_req, inst_rvalid, stallreq); end
      step(); mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001; #1;
      n_cmp++; if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h2408_0001) begin n_err++; $display("FAIL fetch_c4 got rv=%0h rdata=%h exp 1 24080001", inst_rvalid, inst_rdata); end
      n_cmp++; if (stallreq !== 1'b0 || data_rvalid !== 1'b0) begin n_err++; $display("FAIL fetch_c4_stall got stall=%0h drv=%0h exp 0 0", stallreq, data_rvalid); end
      step(); mem_data_ok = 1'b0; inst_req = 1'b0; #1;
      n_cmp++; if (inst_rvalid !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL fetch_c5 got rv=%0h req=%0h exp 0 0", inst_rvalid, mem_req); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      step();
      inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
      data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL sim_c0 got req=%0h exp=0", mem_req); end
      step(); mem_addr_ok = 1'b1; #1;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 4'hF || mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sim_store got req=%0h addr=%h wen=%h wd=%h", mem_req, mem_addr, mem_wen, mem_wdata); end
      step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
      n_cmp++; if (data_rvalid !== 1'b1 || inst_rvalid !== 1'b0 || stallreq !== 1'b1) begin n_err++; $display("FAIL sim_store_done got drv=%0h irv=%0h stall=%0h exp 1 0 1", data_rvalid, inst_rvalid, stallreq); end
      step(); mem_data_ok = 1'b0; data_req = 1'b0; #1;
      n_cmp++; if (mem_req !== 1'b0 || data_rvalid !== 1'b0) begin n_err++; $display("FAIL sim_idle got req=%0h drv=%0h exp 0 0", mem_req, data_rvalid); end
      step(); mem_addr_ok = 1'b1; #1;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0004 || mem_wen !== 4'h0) begin n_err++; $display("FAIL sim_fetch got req=%0h addr=%h wen=%h", mem_req, mem_addr, mem_wen); end
      step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1122_3344; #1;
      n_cmp++; if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h1122_3344 || data_rvalid !== 1'b0) begin n_err++; $display("FAIL sim_fetch_done got irv=%0h rd=%h drv=%0h", inst_rvalid, inst_rdata, data_rvalid); end
      step(); clear_inputs();
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_ord;
`ifdef ARB_ROUND_ROBIN_EN
      exp_ord = 3'b101;
`else
      exp_ord = 3'b111;
`endif
      apply_reset();
      for (int g = 0; g < 3; g++) begin
         step();
         mem_data_ok = 1'b0;
         inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
         data_req = 1'b1; data_addr = 32'h8000_0200; data_wen = 4'h0; #1;
         n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL b2b_idle%0d got=%0h exp=0", g, mem_req); end
         step(); mem_addr_ok = 1'b1; #1;
         n_cmp++; if (mem_req !== 1'b1 || mem_addr !== (exp_ord[g] ? 32'h8000_0200 : 32'hBFC0_0100)) begin n_err++; $display("FAIL b2b_grant%0d got req=%0h addr=%h exp_data=%0h", g, mem_req, mem_addr, exp_ord[g]); end
         step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hC0DE_0000 + 32'(g); #1;
         n_cmp++; if (data_rvalid !== exp_ord[g] || inst_rvalid !== !exp_ord[g]) begin n_err++; $display("FAIL b2b_done%0d got drv=%0h irv=%0h exp_data=%0h", g, data_rvalid, inst_rvalid, exp_ord[g]); end
      end
      step(); clear_inputs();
   endtask

   task automatic test_addr_stall();
      apply_reset();
      step(); data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h8000_2468; data_wdata = 32'h0;
      for (int c = 1; c <= 5; c++) begin
         step();
         mem_data_ok = (c == 3) ? 1'b1 : 1'b0;
         mem_rdata = 32'hBAD0_0000 + 32'(c); #1;
         n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_2468) begin n_err++; $display("FAIL stall_hold%0d got req=%0h addr=%h exp 1 80002468", c, mem_req, mem_addr); end
         n_cmp++; if (data_rvalid !== 1'b0 || stallreq !== 1'b1) begin n_err++; $display("FAIL stall_rv%0d got rv=%0h stall=%0h exp 0 1", c, data_rvalid, stallreq); end
      end
      step(); mem_data_ok = 1'b0; mem_addr_ok = 1'b1; #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL stall_accept got=%0h exp=1", mem_req); end
      step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0F0F_1234; #1;
      n_cmp++; if (mem_req !== 1'b0 || data_rvalid !== 1'b1 || data_rdata !== 32'h0F0F_1234) begin n_err++; $display("FAIL stall_done got req=%0h rv=%0h rd=%h", mem_req, data_rvalid, data_rdata); end
      step(); clear_inputs();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
      step(); mem_addr_ok = 1'b1;
      step(); mem_addr_ok = 1'b0; rst = 1'b1; #1;
      n_cmp++; if (mem_req !== 1'b0 || inst_rvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_resp got req=%0h rv=%0h exp 0 0", mem_req, inst_rvalid); end
      step(); rst = 1'b0; inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777; #1;
      n_cmp++; if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL rstmid_stale got irv=%0h drv=%0h req=%0h exp 0 0 0", inst_rvalid, data_rvalid, mem_req); end
      step(); mem_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h8000_0004; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rstmid_idle got=%0h exp=0", mem_req); end
      step(); #1;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0004) begin n_err++; $display("FAIL rstmid_newreq got req=%0h addr=%h", mem_req, mem_addr); end
      step(); clear_inputs();
   endtask

   // Random traffic against a transaction-level model: one outstanding access,
   // arbitration only while idle, completion only after acceptance.
   task automatic test_random();
      bit          ip, dp, busy, acc, own, last, exp_done, exp_irv, exp_drv;
      logic [31:0] ia, da, dwd, tmp;
      logic [3:0]  dwen;
      int          r;
      apply_reset();
      ip = 1'b0; dp = 1'b0; busy = 1'b0; acc = 1'b0; own = 1'b0; last = 1'b0;
      ia = 32'h0; da = 32'h0; dwd = 32'h0; dwen = 4'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1'b1; tmp = $urandom(); ia = {4'hB, tmp[27:2], 2'b00};
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1'b1; tmp = $urandom(); da = {4'h8, tmp[27:2], 2'b00};
            dwd = $urandom(); r = $urandom_range(0, 3);
            tmp = $urandom();
            dwen = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : tmp[3:0];
         end
         inst_req = ip; inst_addr = ia;
         data_req = dp; data_addr = da; data_wen = dwen; data_wdata = dwd;
         mem_addr_ok = ($urandom_range(0, 2) == 0);
         mem_data_ok = acc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         mem_rdata = $urandom();
         #1;
         exp_done = busy && acc && mem_data_ok;
         exp_irv = exp_done && !own;
         exp_drv = exp_done && own;
         n_cmp++; if (mem_req !== (busy && !acc)) begin n_err++; $display("FAIL rnd_req cyc=%0d got=%0h exp=%0h", cyc, mem_req, busy && !acc); end
         if (busy && !acc) begin
            n_cmp++; if (mem_addr !== (own ? da : ia) || mem_wen !== (own ? dwen : 4'h0)) begin n_err++; $display("FAIL rnd_fields cyc=%0d got addr=%h wen=%h exp addr=%h wen=%h", cyc, mem_addr, mem_wen, own ? da : ia, own ? dwen : 4'h0); end
            if (own) begin
               n_cmp++; if (mem_wdata !== dwd) begin n_err++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, dwd); end
            end
         end
         n_cmp++; if (inst_rvalid !== exp_irv || data_rvalid !== exp_drv) begin n_err++; $display("FAIL rnd_rvalid cyc=%0d got i=%0h d=%0h exp i=%0h d=%0h", cyc, inst_rvalid, data_rvalid, exp_irv, exp_drv); end
         if (exp_irv) begin
            n_cmp++; if (inst_rdata !== mem_rdata) begin n_err++; $display("FAIL rnd_irdata cyc=%0d got=%h exp=%h", cyc, inst_rdata, mem_rdata); end
         end
         if (exp_drv && dwen == 4'h0) begin
            n_cmp++; if (data_rdata !== mem_rdata) begin n_err++; $display("FAIL rnd_drdata cyc=%0d got=%h exp=%h", cyc, data_rdata, mem_rdata); end
         end
         n_cmp++; if (stallreq !== ((ip && !exp_irv) || (dp && !exp_drv))) begin n_err++; $display("FAIL rnd_stall cyc=%0d got=%0h", cyc, stallreq); end
         if (!busy) begin
            if (ip || dp) begin
`ifdef ARB_ROUND_ROBIN_EN
               own = (ip && dp) ? !last : dp;
`else
               own = dp;
`endif
               last = own; busy = 1'b1; acc = 1'b0;
            end
         end else if (!acc) begin
            if (mem_addr_ok) acc = 1'b1;
         end else if (mem_data_ok) begin
            busy = 1'b0; acc = 1'b0;
            if (own) dp = 1'b0; else ip = 1'b0;
         end
      end
      step(); clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_lone_fetch();
      test_simultaneous();
      test_back_to_back();
      test_addr_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
